// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkgen_pkg;

  localparam int CW_DEF       = 32;  // default half-period counter width
  localparam int DEF_HALF_DEF = 1;   // default reset half-period (clkin/2)
  localparam int CW_MAX       = 64;  // widest counter the helpers handle

  // {hi,lo} phase-length record at the default counter width.
  typedef struct packed {
    logic [CW_DEF-1:0] hi;
    logic [CW_DEF-1:0] lo;
  } len_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A zero-length phase would never toggle, so 0 is promoted to 1.
  function automatic logic [CW_MAX-1:0] clamp1(input logic [CW_MAX-1:0] v);
    return (v == '0) ? CW_MAX'(1) : v;
  endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: phase counter, output level, rise tick and the
// active/pending phase-length registers. A pending length is adopted at
// the end of a low->high->low period, or at once while frozen low.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [CW-1:0] i_hi,
  input  logic [CW-1:0] i_lo,
  output logic          o_clk,
  output logic          o_tick
);

  typedef struct packed {
    logic [CW-1:0] hi;
    logic [CW-1:0] lo;
  } chan_len_t;

  localparam logic [CW-1:0] DEF_LEN = CW'(clamp1(CW_MAX'(DEF_HALF)));
  localparam chan_len_t     DEF_REC = '{hi: DEF_LEN, lo: DEF_LEN};

  chan_len_t     r_act;
  chan_len_t     r_pend;
  logic          r_pend_v;
  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          r_tick;

  chan_len_t     w_new;
  logic [CW-1:0] w_len;
  logic [CW:0]   w_nxt;
  logic          w_wrap;
  logic          w_apply;

  assign w_new.hi = CW'(clamp1(CW_MAX'(i_hi)));
  assign w_new.lo = CW'(clamp1(CW_MAX'(i_lo)));

  // Length of the phase currently being counted.
  assign w_len  = r_clk ? r_act.hi : r_act.lo;
  // One extra bit so the increment never wraps before the compare.
  assign w_nxt  = {1'b0, r_cnt} + 1'b1;
  // >= rather than == so a shrunk length can never miss its toggle.
  assign w_wrap = w_nxt >= {1'b0, w_len};
  // Adopt pending at the high->low toggle, or immediately while frozen low.
  assign w_apply = r_pend_v & (i_en ? (w_wrap & r_clk) : ~r_clk);

  // Counter, output level, tick and length registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_cnt    <= '0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
      r_act    <= DEF_REC;
      r_pend   <= DEF_REC;
      r_pend_v <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_en) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else begin
          r_cnt <= w_nxt[CW-1:0];
        end
      end else if (w_apply) begin
        r_cnt <= '0;
      end
      // Apply consumes the old pending value; a same-cycle write re-arms it.
      if (w_apply) r_act <= r_pend;
      if (i_we) begin
        r_pend   <= w_new;
        r_pend_v <= 1'b1;
      end else if (w_apply) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel runtime-programmable clock divider with clkin-domain ticks.
// Optional: define CLKGEN_DUTY_EN to add i_cfg_lo and separate low-phase
// lengths; otherwise both phases use i_cfg_half (50% duty).
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CW       = CW_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF,
  localparam int CHW     = chw(NCH)
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic [NCH-1:0]  i_clken,
  input  logic            i_cfg_we,
  input  logic [CHW-1:0]  i_cfg_ch,
  input  logic [CW-1:0]   i_cfg_half,
`ifdef CLKGEN_DUTY_EN
  input  logic [CW-1:0]   i_cfg_lo,
`endif
  output logic            o_cfg_ack,
  output logic            o_cfg_err,
  output logic [NCH-1:0]  o_clkout,
  output logic [NCH-1:0]  o_tick
);

  logic [31:0]    w_ch_ext;
  logic           w_valid;
  logic [NCH-1:0] w_we;
  logic [CW-1:0]  w_lo;
  logic           r_ack;
  logic           r_err;

  assign w_ch_ext = 32'(i_cfg_ch);
  assign w_valid  = w_ch_ext < 32'(NCH);

`ifdef CLKGEN_DUTY_EN
  assign w_lo = i_cfg_lo;
`else
  assign w_lo = i_cfg_half;
`endif

  // Handshake: ack every write one cycle later, flag out-of-range channels.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= i_cfg_we;
      r_err <= i_cfg_we & ~w_valid;
    end
  end

  assign o_cfg_ack = r_ack;
  assign o_cfg_err = r_err;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // Invalid channel numbers decode to no write enable at all.
    assign w_we[g] = i_cfg_we & w_valid & (w_ch_ext == 32'(g));

    clkgen_chan #(
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clkin  (clkin),
      .rst    (rst),
      .i_en   (i_clken[g]),
      .i_we   (w_we[g]),
      .i_hi   (i_cfg_half),
      .i_lo   (w_lo),
      .o_clk  (o_clkout[g]),
      .o_tick (o_tick[g])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi (5 channels so an out-of-range select exists).
module tb_clkgen_multi;
  localparam int NCH = 5;
  localparam int CW  = 32;
  localparam int CHW = 3;

  logic           clkin = 1'b0;
  logic           rst;
  logic [NCH-1:0] clken;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_half;
`ifdef CLKGEN_DUTY_EN
  logic [CW-1:0]  cfg_lo;
`endif
  logic           cfg_ack;
  logic           cfg_err;
  logic [NCH-1:0] clkout;
  logic [NCH-1:0] tick;

  int n_chk = 0;
  int n_err = 0;

  clkgen_multi #(.NCH(NCH), .CW(CW), .DEF_HALF(1)) dut (
    .clkin      (clkin),
    .rst        (rst),
    .i_clken    (clken),
    .i_cfg_we   (cfg_we),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_half (cfg_half),
`ifdef CLKGEN_DUTY_EN
    .i_cfg_lo   (cfg_lo),
`endif
    .o_cfg_ack  (cfg_ack),
    .o_cfg_err  (cfg_err),
    .o_clkout   (clkout),
    .o_tick     (tick)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int half, input int lo);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_half = CW'(half);
`ifdef CLKGEN_DUTY_EN
    cfg_lo   = CW'(lo);
`else
    if (lo != half) $display("note: low length ignored without duty option");
`endif
  endtask

  // Wait for a rise on channel ch, then count high and low samples.
  task automatic meas(input int ch, output int hi, output int lo);
    int n;
    hi = 0;
    lo = 0;
    n  = 0;
    while (!tick[ch] && n < 200) begin
      step();
      n++;
    end
    if (tick[ch]) begin
      while (clkout[ch] && hi < 200) begin
        hi++;
        step();
      end
      while (!clkout[ch] && lo < 200) begin
        lo++;
        step();
      end
    end
  endtask

  initial begin
    int hi, lo, n;
    logic held;
    rst = 1'b1; clken = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef CLKGEN_DUTY_EN
    cfg_lo = '0;
`endif
    step(2);
    chk("rst_clk", 32'(clkout), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ack", 32'(cfg_ack), 0);
    chk("rst_err", 32'(cfg_err), 0);

    // Default half=1: every channel toggles each cycle, tick on each rise.
    rst = 1'b0; clken = '1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("div2_clk", 32'(clkout), (k % 2) ? 32'h1F : 32'h0);
      chk("div2_tick", 32'(tick), (k % 2) ? 32'h1F : 32'h0);
      chk("div2_ack", 32'(cfg_ack), 0);
    end

    // ch2 half=3 written while high.
    step();
    wr(2, 3, 3);
    step();
    chk("w2_ack", 32'(cfg_ack), 1);
    chk("w2_err", 32'(cfg_err), 0);
    cfg_we = 1'b0;
    step();
    chk("w2_ack_drop", 32'(cfg_ack), 0);
    step(10);
    meas(2, hi, lo);
    chk("ch2_hi", hi, 3);
    chk("ch2_lo", lo, 3);
    meas(0, hi, lo);
    chk("ch0_hi", hi, 1);
    chk("ch0_lo", lo, 1);

    // ch1: 5 then 2 before the period ends; only 2 may take effect.
    n = 0;
    while (!clkout[1] && n < 4) begin step(); n++; end
    wr(1, 5, 5);
    step();
    chk("w1a_ack", 32'(cfg_ack), 1);
    wr(1, 2, 2);
    step();
    chk("w1b_ack", 32'(cfg_ack), 1);
    cfg_we = 1'b0;
    step();
    chk("w1_ack_drop", 32'(cfg_ack), 0);
    step(10);
    meas(1, hi, lo);
    chk("ch1_hi", hi, 2);
    chk("ch1_lo", lo, 2);

    // Out-of-range channel: ack+err, nothing changes.
    wr(5, 7, 7);
    step();
    chk("bad_ack", 32'(cfg_ack), 1);
    chk("bad_err", 32'(cfg_err), 1);
    cfg_we = 1'b0;
    step();
    chk("bad_err_drop", 32'(cfg_err), 0);
    meas(1, hi, lo);
    chk("bad_ch1_hi", hi, 2);
    meas(2, hi, lo);
    chk("bad_ch2_lo", lo, 3);
    meas(0, hi, lo);
    chk("bad_ch0_hi", hi, 1);

    // ch0 half=4; freeze two cycles into the high phase for 10 cycles.
    wr(0, 4, 4);
    step();
    cfg_we = 1'b0;
    step(12);
    n = 0;
    while (!tick[0] && n < 20) begin step(); n++; end
    chk("frz_rise", 32'(tick[0]), 1);
    step();
    chk("frz_pre", 32'(clkout[0]), 1);
    clken[0] = 1'b0;
    held = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!clkout[0] || tick[0]) held = 1'b0;
    end
    chk("frz_hold", 32'(held), 1);
    clken[0] = 1'b1;
    n = 0;
    step();
    while (clkout[0] && n < 20) begin n++; step(); end
    chk("frz_hi_total", 2 + n, 4);

    // Reset mid-run with a write present: everything back to default.
    rst = 1'b1;
    wr(2, 9, 9);
    step();
    chk("rst2_clk", 32'(clkout), 0);
    chk("rst2_tick", 32'(tick), 0);
    chk("rst2_ack", 32'(cfg_ack), 0);
    rst = 1'b0; cfg_we = 1'b0;
    meas(2, hi, lo);
    chk("rst2_ch2_hi", hi, 1);
    chk("rst2_ch2_lo", lo, 1);
    meas(0, hi, lo);
    chk("rst2_ch0_hi", hi, 1);

    // Zero length is treated as one.
    wr(4, 2, 2);
    step();
    cfg_we = 1'b0;
    step(10);
    meas(4, hi, lo);
    chk("ch4_hi2", hi, 2);
    wr(4, 0, 0);
    step();
    cfg_we = 1'b0;
    step(10);
    meas(4, hi, lo);
    chk("ch4_zero_hi", hi, 1);
    chk("ch4_zero_lo", lo, 1);

`ifdef CLKGEN_DUTY_EN
    // Asymmetric duty: 2 high, 5 low, 7-cycle period.
    wr(3, 2, 5);
    step();
    cfg_we = 1'b0;
    step(16);
    meas(3, hi, lo);
    chk("duty_hi", hi, 2);
    chk("duty_lo", lo, 5);
    chk("duty_per", hi + lo, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
